// File: rtl/cfg_access_arb_pkg.sv
// Shared types and constants for the config register bank access arbiter.
package cfg_access_arb_pkg;

    localparam int CFG_REGS = 16;
    localparam int CFG_AW   = 4;
    localparam int CFG_DW   = 8;

    localparam logic [CFG_AW-1:0] CFG_REG_VOL  = 4'd3;
    localparam logic [CFG_AW-1:0] CFG_REG_CTRL = 4'd7;
    localparam logic [CFG_AW-1:0] CFG_REG_MENU = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PI_WR   = 2'd1,
        INT_ACK = 2'd2
    } cfg_arb_st_t;

    typedef struct packed {
        logic ce_cfg;
    } pi_map_t;

    // PI decode forwards only the config register index on addr.
    typedef struct packed {
        logic              act;
        logic              we;
        logic [CFG_AW-1:0] addr;
        logic [CFG_DW-1:0] dato;
        pi_map_t           map;
    } pi_bus_t;

    function automatic logic [CFG_REGS-1:0] cfg_onehot(input logic [CFG_AW-1:0] idx);
        return {{(CFG_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/cfg_access_arb_pend_buf.sv
// One-deep holding register for a PI config write waiting for its bank slot.
module cfg_pend_buf
    import cfg_access_arb_pkg::*;
#(
    parameter logic [3:0] MAX_WAIT = 4'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic              retire_i,
    input  logic [CFG_AW-1:0] cap_addr_i,
    input  logic [CFG_DW-1:0] cap_dat_i,
    output logic              pend_v_o,
    output logic [CFG_AW-1:0] pend_addr_o,
    output logic [CFG_DW-1:0] pend_dat_o,
    output logic              ovf_o
);

    logic              accept_s, hold_s, stale_s;
    logic              pend_v_q, pend_v_d;
    logic [CFG_AW-1:0] pend_addr_q, pend_addr_d;
    logic [CFG_DW-1:0] pend_dat_q, pend_dat_d;
    logic [3:0]        wait_q, wait_d;
    logic              ovf_q, ovf_d;

    // Next-state for the holding slot, its age counter and the sticky overflow flag.
    always_comb begin
        accept_s = capture_i & (~pend_v_q | retire_i);
        hold_s   = pend_v_q & ~retire_i;
        stale_s  = hold_s & (wait_q == MAX_WAIT);
        if (accept_s) begin
            pend_v_d    = 1'b1;
            pend_addr_d = cap_addr_i;
            pend_dat_d  = cap_dat_i;
        end else if (retire_i) begin
            pend_v_d    = 1'b0;
            pend_addr_d = pend_addr_q;
            pend_dat_d  = pend_dat_q;
        end else begin
            pend_v_d    = pend_v_q;
            pend_addr_d = pend_addr_q;
            pend_dat_d  = pend_dat_q;
        end
        if (hold_s && !stale_s) begin
            wait_d = wait_q + 4'd1;
        end else if (hold_s) begin
            wait_d = wait_q;
        end else begin
            wait_d = 4'd0;
        end
        // A dropped write, or one held past MAX_WAIT, is reported as overflow.
        ovf_d = ovf_q | (capture_i & ~accept_s) | stale_s;
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= 4'd0;
            pend_dat_q  <= 8'd0;
            wait_q      <= 4'd0;
            ovf_q       <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_dat_q  <= pend_dat_d;
            wait_q      <= wait_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pend_v_o    = pend_v_q;
    assign pend_addr_o = pend_addr_q;
    assign pend_dat_o  = pend_dat_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/cfg_access_arb.sv
// Arbitrates the 16x8 config register bank between the PI host bus and one internal master,
// and tracks which registers the host has rewritten.
module cfg_access_arb
    import cfg_access_arb_pkg::*;
#(
    parameter logic [CFG_REGS-1:0] INT_WR_MASK = 16'h0108,
    parameter logic [3:0]          MAX_WAIT    = 4'd8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  pi_bus_t             pi_i,
    input  logic                int_req_i,
    input  logic                int_we_i,
    input  logic [CFG_AW-1:0]   int_addr_i,
    input  logic [CFG_DW-1:0]   int_wdat_i,
    output logic                int_ack_o,
    output logic                int_err_o,
    output logic [CFG_DW-1:0]   int_rdat_o,
    output logic                rf_we_o,
    output logic [CFG_AW-1:0]   rf_addr_o,
    output logic [CFG_DW-1:0]   rf_wdat_o,
    input  logic [CFG_DW-1:0]   rf_rdat_i,
    output logic [CFG_REGS-1:0] dirty_o,
    input  logic [CFG_REGS-1:0] dirty_clr_i,
    output logic                ovf_o
);

    cfg_arb_st_t         state_q;
    logic                strobe_s, retire_s, pend_v_s;
    logic [CFG_AW-1:0]   pend_addr_s;
    logic [CFG_DW-1:0]   pend_dat_s;
    logic                rf_we_q, int_ack_q, int_err_q;
    logic [CFG_AW-1:0]   rf_addr_q;
    logic [CFG_DW-1:0]   rf_wdat_q, int_rdat_q;
    logic [CFG_REGS-1:0] dirty_q, dirty_d;

    assign strobe_s = pi_i.act & pi_i.we & pi_i.map.ce_cfg;
    assign retire_s = (state_q == PI_WR);

    cfg_pend_buf #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pend (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_i   (strobe_s),
        .retire_i    (retire_s),
        .cap_addr_i  (pi_i.addr),
        .cap_dat_i   (pi_i.dato),
        .pend_v_o    (pend_v_s),
        .pend_addr_o (pend_addr_s),
        .pend_dat_o  (pend_dat_s),
        .ovf_o       (ovf_o)
    );

    // Arbitration FSM with registered bank and internal-master outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= 4'd0;
            rf_wdat_q  <= 8'd0;
            int_ack_q  <= 1'b0;
            int_err_q  <= 1'b0;
            int_rdat_q <= 8'd0;
        end else begin
            rf_we_q   <= 1'b0;
            int_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_v_s) begin
                        state_q <= PI_WR;
                    end else if (strobe_s) begin
                        // A PI write landing this edge goes ahead of a same-edge internal request.
                        state_q <= IDLE;
                    end else if (int_req_i) begin
                        rf_addr_q <= int_addr_i;
                        rf_wdat_q <= int_wdat_i;
                        rf_we_q   <= int_we_i & INT_WR_MASK[int_addr_i];
                        state_q   <= INT_ACK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PI_WR: begin
                    rf_we_q   <= 1'b1;
                    rf_addr_q <= pend_addr_s;
                    rf_wdat_q <= pend_dat_s;
                    state_q   <= IDLE;
                end
                INT_ACK: begin
                    // rf_addr still points at the internal register, so rf_rdat is its value.
                    int_ack_q <= 1'b1;
                    int_err_q <= int_we_i & ~INT_WR_MASK[rf_addr_q];
                    if (!int_we_i) begin
                        int_rdat_q <= rf_rdat_i;
                    end
                    state_q <= pend_v_s ? PI_WR : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Host-write tracking: a PI retire wins over a same-cycle clear.
    always_comb begin
        dirty_d = dirty_q & ~dirty_clr_i;
        if (retire_s) begin
            dirty_d = dirty_d | cfg_onehot(pend_addr_s);
        end else begin
            dirty_d = dirty_d;
        end
    end

    // Dirty bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= 16'd0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_addr_o  = rf_addr_q;
    assign rf_wdat_o  = rf_wdat_q;
    assign int_ack_o  = int_ack_q;
    assign int_err_o  = int_err_q;
    assign int_rdat_o = int_rdat_q;
    assign dirty_o    = dirty_q;

endmodule

// File: tb/tb_cfg_access_arb.sv
// Self-checking bench for cfg_access_arb: hand sequences for timing corners plus a vector table,
// with a write scoreboard watching every bank write.
module tb_cfg_access_arb;
    import cfg_access_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    pi_bus_t     pi;
    logic        int_req, int_we;
    logic [3:0]  int_addr;
    logic [7:0]  int_wdat;
    logic        int_ack, int_err;
    logic [7:0]  int_rdat;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wdat, rf_rdat;
    logic [15:0] dirty, dirty_clr;
    logic        ovf;

    cfg_access_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pi_i        (pi),
        .int_req_i   (int_req),
        .int_we_i    (int_we),
        .int_addr_i  (int_addr),
        .int_wdat_i  (int_wdat),
        .int_ack_o   (int_ack),
        .int_err_o   (int_err),
        .int_rdat_o  (int_rdat),
        .rf_we_o     (rf_we),
        .rf_addr_o   (rf_addr),
        .rf_wdat_o   (rf_wdat),
        .rf_rdat_i   (rf_rdat),
        .dirty_o     (dirty),
        .dirty_clr_i (dirty_clr),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    // Register bank stand-in
    logic [7:0] bank [16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
        end else if (rf_we) begin
            bank[rf_addr] <= rf_wdat;
        end
    end
    assign rf_rdat = bank[rf_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every expected bank write is queued when its stimulus is driven.
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wr_q[$];
    wr_t wr_e;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_write: got addr %h data %h expected no write", rf_addr, rf_wdat);
            end else begin
                wr_e = wr_q.pop_front();
                check("sb_wr_addr", {12'd0, rf_addr}, {12'd0, wr_e.a});
                check("sb_wr_data", {8'd0, rf_wdat}, {8'd0, wr_e.d});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pi_drive(input logic [3:0] a, input logic [7:0] d);
        pi.act        = 1'b1;
        pi.we         = 1'b1;
        pi.map.ce_cfg = 1'b1;
        pi.addr       = a;
        pi.dato       = d;
    endtask

    task automatic pi_idle();
        pi = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pi_idle();
        int_req   = 1'b0;
        int_we    = 1'b0;
        int_addr  = 4'd0;
        int_wdat  = 8'd0;
        dirty_clr = 16'd0;
        wr_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for int_ack and drops int_req within the ack cycle.
    task automatic wait_ack(input string name, output logic err, output logic [7:0] rdat);
        logic seen;
        seen = 1'b0;
        err  = 1'bx;
        rdat = 8'hxx;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (int_ack === 1'b1) begin
                seen    = 1'b1;
                err     = int_err;
                rdat    = int_rdat;
                int_req = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no int_ack expected int_ack within 10 cycles", name);
            int_req = 1'b0;
        end
    endtask

    typedef struct {
        bit         is_int;
        bit         we;
        logic [3:0] a;
        logic [7:0] d;
        logic       exp_err;
        logic [7:0] exp_rdat;
    } vec_t;
    vec_t vecs[11];

    logic       err_v;
    logic [7:0] rdat_v;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd4,  8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 4'd8,  8'h3C, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 4'd4,  8'h00, 1'b0, 8'hA5};
        vecs[3]  = '{1'b1, 1'b1, 4'd8,  8'h77, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 4'd8,  8'h00, 1'b0, 8'h77};
        vecs[5]  = '{1'b1, 1'b1, 4'd4,  8'h11, 1'b1, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 4'd4,  8'h00, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 4'd3,  8'h01, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 8'h01};
        vecs[9]  = '{1'b1, 1'b1, 4'd15, 8'hFF, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 8'h00};

        do_reset();
        @(negedge clk);
        check("rst_rf_we",    {15'd0, rf_we},    16'd0);
        check("rst_rf_addr",  {12'd0, rf_addr},  16'd0);
        check("rst_rf_wdat",  {8'd0, rf_wdat},   16'd0);
        check("rst_int_ack",  {15'd0, int_ack},  16'd0);
        check("rst_int_err",  {15'd0, int_err},  16'd0);
        check("rst_int_rdat", {8'd0, int_rdat},  16'd0);
        check("rst_dirty",    dirty,             16'd0);
        check("rst_ovf",      {15'd0, ovf},      16'd0);
        tick();

        // PI write reg 1 = 3F: rf_we two cycles after the strobe edge
        pi_drive(4'd1, 8'h3F);
        wr_q.push_back({4'd1, 8'h3F});
        tick();
        pi_idle();
        @(negedge clk);
        check("pi_lat_c0", {15'd0, rf_we}, 16'd0);
        tick();
        @(negedge clk);
        check("pi_lat_c1", {15'd0, rf_we}, 16'd0);
        tick();
        @(negedge clk);
        check("pi_lat_c2_we",   {15'd0, rf_we}, 16'd1);
        check("pi_lat_c2_addr", {12'd0, rf_addr}, 16'd1);
        check("pi_lat_c2_wdat", {8'd0, rf_wdat}, 16'h003F);
        check("pi_dirty", dirty, 16'h0002);
        tick();

        // Load reg 7 = 80 over PI, then internal read of reg 7
        pi_drive(4'd7, 8'h80);
        wr_q.push_back({4'd7, 8'h80});
        tick();
        pi_idle();
        repeat (4) tick();
        int_we = 1'b0; int_addr = 4'd7; int_req = 1'b1;
        tick();
        @(negedge clk);
        check("rd7_ack_c0", {15'd0, int_ack}, 16'd0);
        tick();
        @(negedge clk);
        check("rd7_ack_c1", {15'd0, int_ack}, 16'd1);
        check("rd7_rdat",   {8'd0, int_rdat}, 16'h0080);
        check("rd7_err",    {15'd0, int_err}, 16'd0);
        int_req = 1'b0;
        tick();
        @(negedge clk);
        check("rd7_ack_single", {15'd0, int_ack}, 16'd0);
        tick();

        // Internal write reg 3 = 40 (permitted)
        int_we = 1'b1; int_addr = 4'd3; int_wdat = 8'h40; int_req = 1'b1;
        wr_q.push_back({4'd3, 8'h40});
        tick();
        @(negedge clk);
        check("wr3_issue_we",   {15'd0, rf_we},   16'd1);
        check("wr3_issue_addr", {12'd0, rf_addr}, 16'd3);
        check("wr3_issue_ack",  {15'd0, int_ack}, 16'd0);
        tick();
        @(negedge clk);
        check("wr3_ack",   {15'd0, int_ack}, 16'd1);
        check("wr3_err",   {15'd0, int_err}, 16'd0);
        check("wr3_dirty", dirty, 16'h0082);
        int_req = 1'b0;
        tick();

        // Internal write reg 0 (masked): refused with error
        int_we = 1'b1; int_addr = 4'd0; int_wdat = 8'h55; int_req = 1'b1;
        tick();
        @(negedge clk);
        check("wr0_no_we", {15'd0, rf_we}, 16'd0);
        tick();
        @(negedge clk);
        check("wr0_ack", {15'd0, int_ack}, 16'd1);
        check("wr0_err", {15'd0, int_err}, 16'd1);
        int_req = 1'b0;
        tick();

        // PI strobe and internal read of reg 5 on the same edge: PI lands first
        pi_drive(4'd5, 8'h5A);
        wr_q.push_back({4'd5, 8'h5A});
        int_we = 1'b0; int_addr = 4'd5; int_req = 1'b1;
        tick();
        pi_idle();
        wait_ack("same_edge", err_v, rdat_v);
        check("same_edge_pi_first", wr_q.size(), 16'd0);
        check("same_edge_rdat", {8'd0, rdat_v}, 16'h005A);
        check("same_edge_err",  {15'd0, err_v}, 16'd0);
        tick();

        // dirty_clr coinciding with a PI retire to reg 1
        dirty_clr = 16'h0002;
        tick();
        dirty_clr = 16'd0;
        @(negedge clk);
        check("clr_pre", dirty, 16'h00A0);
        tick();
        pi_drive(4'd1, 8'hC3);
        wr_q.push_back({4'd1, 8'hC3});
        tick();
        pi_idle();
        tick();
        dirty_clr = 16'h0002;
        tick();
        dirty_clr = 16'd0;
        @(negedge clk);
        check("clr_set_wins", dirty, 16'h00A2);
        tick();
        dirty_clr = 16'h0002;
        tick();
        dirty_clr = 16'd0;
        @(negedge clk);
        check("clr_after", dirty, 16'h00A0);
        tick();

        // Two PI strobes on consecutive edges during an internal read of reg 2
        int_we = 1'b0; int_addr = 4'd2; int_req = 1'b1;
        tick();
        pi_drive(4'd9, 8'h11);
        wr_q.push_back({4'd9, 8'h11});
        tick();
        pi_drive(4'd10, 8'h22);
        @(negedge clk);
        check("ovf_seq_ack",  {15'd0, int_ack}, 16'd1);
        check("ovf_seq_rdat", {8'd0, int_rdat}, 16'h0000);
        check("ovf_seq_pre",  {15'd0, ovf}, 16'd0);
        int_req = 1'b0;
        tick();
        pi_idle();
        repeat (3) tick();
        @(negedge clk);
        check("ovf_set",       {15'd0, ovf}, 16'd1);
        check("ovf_seq_dirty", dirty, 16'h02A0);
        tick();

        // Reset with a PI write still pending: write lost, no overflow
        pi_drive(4'd6, 8'h66);
        tick();
        pi_idle();
        #2;
        rst_n = 1'b0;
        #2;
        check("async_rst_ovf",   {15'd0, ovf}, 16'd0);
        check("async_rst_dirty", dirty, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("post_rst_dirty", dirty, 16'd0);
        check("post_rst_ovf",   {15'd0, ovf}, 16'd0);
        tick();

        // Vector table
        for (int i = 0; i < 11; i++) begin
            if (!vecs[i].is_int) begin
                pi_drive(vecs[i].a, vecs[i].d);
                wr_q.push_back({vecs[i].a, vecs[i].d});
                tick();
                pi_idle();
                repeat (3) tick();
            end else begin
                int_we   = vecs[i].we;
                int_addr = vecs[i].a;
                int_wdat = vecs[i].d;
                if (vecs[i].we && !vecs[i].exp_err) wr_q.push_back({vecs[i].a, vecs[i].d});
                int_req = 1'b1;
                wait_ack($sformatf("vec%0d", i), err_v, rdat_v);
                check($sformatf("vec%0d_err", i), {15'd0, err_v}, {15'd0, vecs[i].exp_err});
                if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), {8'd0, rdat_v}, {8'd0, vecs[i].exp_rdat});
                tick();
            end
        end
        repeat (2) tick();
        @(negedge clk);
        check("vec_dirty", dirty, 16'h0118);
        check("vec_ovf",   {15'd0, ovf}, 16'd0);
        check("sb_drain",  wr_q.size(), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
